// File: rtl/serial_add_seq_pkg.sv
// Shared state encoding for the bit-serial adder sequencer.
package serial_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// One-bit full adder built from two half adders and an OR on their carries.
module half_adder (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module fa_cell (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  logic s0, c0, c1;

  half_adder u_ha0 (.s(s0), .co(c0), .a(a),  .b(b));
  half_adder u_ha1 (.s(s),  .co(c1), .a(s0), .b(ci));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one shared full-adder cell processes the operands LSB first,
// one bit per clock, under a start/busy/done handshake.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             s_bit, c_next;

  fa_cell u_fa (
    .s (s_bit),
    .co(c_next),
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .ci(carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Shift-and-or form keeps the sum insertion legal for WIDTH=1.
        sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = c_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq at WIDTH=8 and WIDTH=1 against A+B.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; optionally disturbs inputs and pulses start mid-run.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input bit disturb);
    logic [8:0] ref_v;
    ref_v = {1'b0, ta} + {1'b0, tb_};
    a = ta; b = tb_; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (disturb) begin
        start = (i == 3);
        a = 8'($urandom); b = 8'($urandom);
      end
      step();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("sum", sum, ref_v[7:0]);
    chk("cout", cout, ref_v[8]);
    step();
    chk("done_single", done, 0);
    chk("sum_held", sum, ref_v[7:0]);
  endtask

  initial begin
    int idle_m, t_m, dut_pulses;
    logic [7:0] oa, ob;
    logic [8:0] ref_v;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_sum1", sum1, 0);

    run_op(8'h0F, 8'h01, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h00, 8'h00, 1'b0);

    // Mid-run start and operand changes must be ignored, no second done.
    run_op(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk("no_requeue_done", done, 0);
      chk("no_requeue_busy", busy, 0);
      step();
    end

    // Abort in RUN cycle 4 after a result with nonzero sum is held.
    run_op(8'hF0, 8'h0F, 1'b0);
    a = 8'h55; b = 8'h66; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", done, 0);
      step();
    end
    run_op(8'h80, 8'h80, 1'b0);

    // Start held high: cycle-level model of accept/run/done timing.
    idle_m = 1; t_m = 0; dut_pulses = 0; oa = '0; ob = '0;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (idle_m != 0) begin
        oa = a; ob = b; t_m = 0; idle_m = 0;
      end else begin
        t_m++;
        if (t_m == 9) idle_m = 1;
      end
      step();
      chk("held_busy", busy, 32'((idle_m == 0) && (t_m < 8)));
      chk("held_done", done, 32'((idle_m == 0) && (t_m == 8)));
      if (done) dut_pulses++;
      if ((idle_m == 0) && (t_m == 8)) begin
        ref_v = {1'b0, oa} + {1'b0, ob};
        chk("held_sum", sum, ref_v[7:0]);
        chk("held_cout", cout, ref_v[8]);
      end
    end
    start = 1'b0;
    chk("held_pulse_count", dut_pulses, 4);
    step();

    // WIDTH=1 instance: all four operand pairs.
    for (int k = 0; k < 4; k++) begin
      a1 = 1'(k >> 1); b1 = 1'(k);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_done_early", done1, 0);
      step();
      chk("w1_done", done1, 1);
      chk("w1_sum", sum1, 32'((k >> 1) ^ (k & 1)));
      chk("w1_cout", cout1, 32'((k >> 1) & k & 1));
      step();
      chk("w1_done_single", done1, 0);
    end

    for (int n = 0; n < 500; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
